// File: rtl/dino_game_ctrl.sv
// Game-flow controller for the dino score datapath: frame divider, IDLE/RUN/PAUSE/OVER FSM,
// score-counter control pulses and session high-score tracking.
module dino_game_ctrl #(
  parameter int TICK_DIV  = 833333,
  parameter int OVER_HOLD = 120,
  parameter int SCORE_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_jump,
  input  logic               btn_pause,
  input  logic               collision,
  input  logic [SCORE_W-1:0] score,
  output logic               game_start,
  output logic               game_over,
  output logic               game_tick,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high
);

  localparam int CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int LOCK_W = $clog2(OVER_HOLD + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_OVER = 2'd3} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [LOCK_W-1:0]  r_lock;
  logic               r_jump_q, r_pause_q;
  logic               r_start, r_over, r_tick;
  logic [SCORE_W-1:0] r_high;
  logic               r_new_high;
  logic               w_rise_jump, w_rise_pause, w_strobe, w_start, w_over, w_unlocked;

  assign w_rise_jump  = btn_jump & ~r_jump_q;
  assign w_rise_pause = btn_pause & ~r_pause_q;
  assign w_strobe     = (r_cnt == CNT_W'(TICK_DIV - 1));
  assign w_unlocked   = (r_lock == LOCK_W'(OVER_HOLD));

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_over  = 1'b0;
    case (r_state)
      S_IDLE: if (w_rise_jump) begin
        w_next  = S_RUN;
        w_start = 1'b1;
      end
      S_RUN: if (collision) begin
        w_next = S_OVER;
        w_over = 1'b1;
      end else if (w_rise_pause) begin
        w_next = S_PAUSE;
      end
      S_PAUSE: if (w_rise_pause) w_next = S_RUN;
      S_OVER: if (w_rise_jump && w_unlocked) begin
        w_next  = S_RUN;
        w_start = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_jump_q  <= 1'b1;
      r_pause_q <= 1'b1;
      r_start   <= 1'b0;
      r_over    <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_jump_q  <= btn_jump;
      r_pause_q <= btn_pause;
      r_start   <= w_start;
      r_over    <= w_over;
      r_tick    <= w_strobe && (r_state == S_RUN) && !collision;
    end
  end

  // Divider restarts on every game_start and holds its phase while paused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_lock <= '0;
    end else begin
      if (w_start)
        r_cnt <= '0;
      else if (r_state != S_PAUSE)
        r_cnt <= w_strobe ? '0 : r_cnt + 1'b1;

      if (w_start)
        r_lock <= '0;
      else if ((r_state == S_OVER) && w_strobe && !w_unlocked)
        r_lock <= r_lock + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_high     <= '0;
      r_new_high <= 1'b0;
    end else if (w_over) begin
      if (score > r_high) begin
        r_high     <= score;
        r_new_high <= 1'b1;
      end else begin
        r_new_high <= 1'b0;
      end
    end else if (w_start) begin
      r_new_high <= 1'b0;
    end
  end

  assign game_start = r_start;
  assign game_over  = r_over;
  assign game_tick  = r_tick;
  assign state      = r_state;
  assign high_score = r_high;
  assign new_high   = r_new_high;

endmodule
